// File: rtl/dbus_dmem_banked_pkg.sv
// Shared constants and helpers for the banked data-memory interconnect.
package dbus_dmem_banked_pkg;

    localparam int unsigned DEF_NCORES     = 4;
    localparam int unsigned DEF_DMEM_ADDRW = 10;
    localparam int unsigned DEF_BANK_BITS  = 2;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned STRB_W         = 4;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_dmem_banked_bank.sv
// One memory bank: round-robin arbiter over the core ports plus a byte-strobed single-port RAM.
module dbus_dmem_banked_bank
    import dbus_dmem_banked_pkg::*;
#(
    parameter int unsigned NCORES = DEF_NCORES,
    parameter int unsigned ROWW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCORES-1:0] req,
    input  logic [NCORES-1:0] wr,
    input  logic [ROWW-1:0]   row   [NCORES],
    input  logic [WORD_W-1:0] wdata [NCORES],
    input  logic [STRB_W-1:0] wstrb [NCORES],
    output logic [NCORES-1:0] grant,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned IW   = idx_w(NCORES);
    localparam int unsigned ROWS = 1 << ROWW;

    logic [IW-1:0]     ptr;
    logic [IW-1:0]     win;
    logic              any;
    logic [IW:0]       cand;
    logic [WORD_W-1:0] mem [ROWS];

    // First requester at or after the pointer, wrapping modulo NCORES.
    always_comb begin
        grant = '0;
        win   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NCORES)) begin
                cand = cand - (IW+1)'(NCORES);
            end
            if (!any && req[cand[IW-1:0]]) begin
                any               = 1'b1;
                win               = cand[IW-1:0];
                grant[cand[IW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= (win == IW'(NCORES - 1)) ? '0 : win + IW'(1);
        end
    end

    // RAM contents are deliberately left unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (any) begin
            if (wr[win]) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wstrb[win][b]) begin
                        mem[row[win]][8*b +: 8] <= wdata[win][8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[row[win]];
            end
        end
    end

endmodule

// File: rtl/dbus_dmem_banked.sv
// Banked shared data memory for NCORES cores with per-core LR/SC reservations.
module dbus_dmem_banked
    import dbus_dmem_banked_pkg::*;
#(
    parameter int unsigned NCORES     = DEF_NCORES,
    parameter int unsigned DMEM_ADDRW = DEF_DMEM_ADDRW,
    parameter int unsigned BANK_BITS  = DEF_BANK_BITS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NCORES-1:0]            re_packed_i,
    input  logic [NCORES-1:0]            we_packed_i,
    input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
    input  logic [WORD_W*NCORES-1:0]     wdata_packed_i,
    input  logic [STRB_W*NCORES-1:0]     wstrb_packed_i,
    input  logic [NCORES-1:0]            is_lr_packed_i,
    input  logic [NCORES-1:0]            is_sc_packed_i,
    output logic [WORD_W*NCORES-1:0]     rdata_packed_o,
    output logic [NCORES-1:0]            stall_packed_o
);

    localparam int unsigned NB   = 1 << BANK_BITS;
    localparam int unsigned ROWW = DMEM_ADDRW - BANK_BITS;
    localparam int unsigned BW   = idx_w(NB);

    logic [DMEM_ADDRW-1:0] addr  [NCORES];
    logic [ROWW-1:0]       row   [NCORES];
    logic [BW-1:0]         bank  [NCORES];
    logic [WORD_W-1:0]     wdata [NCORES];
    logic [STRB_W-1:0]     wstrb [NCORES];

    logic [NCORES-1:0] req, lr_rd, sc_wr, sc_ok, wr_ok, grant, commit, inval;
    logic [NCORES-1:0] bank_req   [NB];
    logic [NCORES-1:0] bank_grant [NB];
    logic [WORD_W-1:0] bank_rdata [NB];

    logic [NCORES-1:0]     rsv_valid, sc_flag, sc_res, vld;
    logic [DMEM_ADDRW-1:0] rsv_addr [NCORES];
    logic [BW-1:0]         sel      [NCORES];
    logic [WORD_W-1:0]     hold     [NCORES];
    logic [WORD_W-1:0]     rd       [NCORES];

    for (genvar c = 0; c < NCORES; c++) begin : g_core
        assign addr[c]  = addr_packed_i[c*DMEM_ADDRW +: DMEM_ADDRW];
        assign wdata[c] = wdata_packed_i[c*WORD_W +: WORD_W];
        assign wstrb[c] = wstrb_packed_i[c*STRB_W +: STRB_W];
        assign row[c]   = addr[c][DMEM_ADDRW-1:BANK_BITS];
        if (BANK_BITS == 0) begin : g_one
            assign bank[c] = '0;
        end else begin : g_many
            assign bank[c] = addr[c][BW-1:0];
        end
        assign sc_ok[c] = rsv_valid[c] && (rsv_addr[c] == addr[c]);
        assign rdata_packed_o[c*WORD_W +: WORD_W] = rd[c];
    end

    // Reset discards all requests, which also forces stall low.
    assign req   = (re_packed_i | we_packed_i) & ~{NCORES{rst_i}};
    assign lr_rd = re_packed_i & ~we_packed_i & is_lr_packed_i;
    assign sc_wr = we_packed_i & is_sc_packed_i;
    assign wr_ok = we_packed_i & (~is_sc_packed_i | sc_ok);

    always_comb begin
        for (int unsigned b = 0; b < NB; b++) begin
            bank_req[b] = '0;
            for (int unsigned c = 0; c < NCORES; c++) begin
                bank_req[b][c] = req[c] && (bank[c] == BW'(b));
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        dbus_dmem_banked_bank #(
            .NCORES (NCORES),
            .ROWW   (ROWW)
        ) u_bank (
            .clk   (clk_i),
            .rst   (rst_i),
            .req   (bank_req[b]),
            .wr    (wr_ok),
            .row   (row),
            .wdata (wdata),
            .wstrb (wstrb),
            .grant (bank_grant[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        grant = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            grant = grant | bank_grant[b];
        end
    end

    assign stall_packed_o = req & ~grant;
    assign commit         = grant & wr_ok;

    // Any committed write to a reserved word kills other cores' reservations on it.
    always_comb begin
        inval = '0;
        for (int unsigned j = 0; j < NCORES; j++) begin
            for (int unsigned k = 0; k < NCORES; k++) begin
                if (j != k && commit[k] && (addr[k] == rsv_addr[j])) begin
                    inval[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NCORES; c++) begin
            rd[c] = hold[c];
            if (vld[c]) begin
                rd[c] = sc_flag[c] ? WORD_W'(sc_res[c]) : bank_rdata[sel[c]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsv_valid <= '0;
            sc_flag   <= '0;
            sc_res    <= '0;
            vld       <= '0;
            for (int unsigned c = 0; c < NCORES; c++) begin
                rsv_addr[c] <= '0;
                sel[c]      <= '0;
                hold[c]     <= '0;
            end
        end else begin
            vld <= grant;
            for (int unsigned c = 0; c < NCORES; c++) begin
                if (grant[c]) begin
                    sel[c]     <= bank[c];
                    sc_flag[c] <= sc_wr[c];
                    sc_res[c]  <= ~sc_ok[c];
                end
                if (vld[c]) begin
                    hold[c] <= rd[c];
                end
                if (grant[c] && lr_rd[c]) begin
                    rsv_valid[c] <= 1'b1;
                    rsv_addr[c]  <= addr[c];
                end else if ((grant[c] && sc_wr[c]) || inval[c]) begin
                    rsv_valid[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_dmem_banked.sv
// Directed bench for dbus_dmem_banked: 4 cores, 4 banks, 8-bit word addresses.
module tb_dbus_dmem_banked;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned BB = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NC-1:0]       re, we, is_lr, is_sc;
    logic [AW*NC-1:0]    addr;
    logic [32*NC-1:0]    wdata;
    logic [4*NC-1:0]     wstrb;
    logic [32*NC-1:0]    rdata;
    logic [NC-1:0]       stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dbus_dmem_banked #(
        .NCORES     (NC),
        .DMEM_ADDRW (AW),
        .BANK_BITS  (BB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .re_packed_i    (re),
        .we_packed_i    (we),
        .addr_packed_i  (addr),
        .wdata_packed_i (wdata),
        .wstrb_packed_i (wstrb),
        .is_lr_packed_i (is_lr),
        .is_sc_packed_i (is_sc),
        .rdata_packed_o (rdata),
        .stall_packed_o (stall)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic r, input logic w, input logic lr,
                         input logic sc, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        re[c]          = r;
        we[c]          = w;
        is_lr[c]       = lr;
        is_sc[c]       = sc;
        addr[c*AW +: AW] = a;
        wdata[c*32 +: 32] = d;
        wstrb[c*4 +: 4]  = s;
    endtask

    task automatic idle(input int c);
        drive(c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    function automatic logic [31:0] rdc(input int c);
        return rdata[c*32 +: 32];
    endfunction

    initial begin
        rst = 1'b1;
        for (int c = 0; c < NC; c++) idle(c);

        // Reset: requests ignored, stall low, rdata zero
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        #1;
        chk("reset_stall", 128'(stall), 128'(4'b0000));
        chk("reset_rdata", rdata, 128'h0);
        idle(0);
        rst = 1'b0;

        // Round-robin on bank 0 starting from pointer 0
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h11, 4'hf);
        drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 32'h22, 4'hf);
        drive(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8, 32'h33, 4'hf);
        #1 chk("rr_t0_stall", 128'(stall), 128'(4'b0110));
        @(negedge clk);
        idle(0);
        #1 chk("rr_t1_stall", 128'(stall), 128'(4'b0100));
        @(negedge clk);
        idle(1);
        #1 chk("rr_t2_stall", 128'(stall), 128'(4'b0000));

        // Pointer wrapped from 3 to 0: core 0 beats core 1
        @(negedge clk);
        idle(2);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 32'h0, 4'h0);
        #1 chk("rot_stall", 128'(stall), 128'(4'b0010));
        @(negedge clk);
        chk("rot_rd_core0", 128'(rdc(0)), 128'(32'h11));
        idle(0);
        #1 chk("rot_core1_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        chk("rot_rd_core1", 128'(rdc(1)), 128'(32'h22));
        chk("hold_core0", 128'(rdc(0)), 128'(32'h11));

        // Parallel writes then parallel reads across four banks
        idle(1);
        drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 32'hB1, 4'hf);
        drive(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 32'hB2, 4'hf);
        drive(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 32'hB3, 4'hf);
        #1 chk("par_wr_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        for (int c = 0; c < NC; c++) drive(c, 1'b1, 1'b0, 1'b0, 1'b0, 8'(c), 32'h0, 4'h0);
        #1 chk("par_rd_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        chk("par_rd_data", rdata, {32'hB3, 32'hB2, 32'hB1, 32'h11});

        // LR/SC success on word 0x10
        for (int c = 0; c < NC; c++) idle(c);
        drive(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h5, 4'hf);
        @(negedge clk);
        idle(3);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("lr_data", 128'(rdc(0)), 128'(32'h5));
        drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h6, 4'hf);
        #1 chk("sc_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        chk("sc_ok_result", 128'(rdc(0)), 128'(32'h0));
        idle(0);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("sc_ok_mem", 128'(rdc(1)), 128'(32'h6));

        // SC failure after another core writes one byte of the reserved word
        idle(1);
        drive(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h11223344, 4'hf);
        @(negedge clk);
        idle(3);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("lr2_data", 128'(rdc(0)), 128'(32'h11223344));
        idle(0);
        drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'hAABBCCDD, 4'b0001);
        @(negedge clk);
        idle(1);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h77, 4'hf);
        #1 chk("sc_fail_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        chk("sc_fail_result", 128'(rdc(0)), 128'(32'h1));
        idle(0);
        drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("sc_fail_mem", 128'(rdc(2)), 128'(32'h112233DD));

        // Reset while core 2 holds a stalled SC
        drive(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h14, 32'h55, 4'hf);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h14, 32'h0, 4'h0);
        @(negedge clk);
        chk("lr3_data", 128'(rdc(2)), 128'(32'h55));
        drive(2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h14, 32'h99, 4'hf);
        drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h18, 32'h0, 4'h0);
        #1 chk("rst_pre_stall", 128'(stall), 128'(4'b0100));
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        #1 chk("rst_sc_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        chk("rst_rdata_zero", rdata, 128'h0);
        rst = 1'b0;
        #1 chk("post_rst_stall", 128'(stall), 128'(4'b0000));
        @(negedge clk);
        chk("post_rst_sc", 128'(rdc(2)), 128'(32'h1));
        idle(2);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h14, 32'h0, 4'h0);
        @(negedge clk);
        chk("post_rst_mem", 128'(rdc(1)), 128'(32'h55));
        idle(1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
